// File: rtl/fp_issue_arbiter_pkg.sv
// Shared types for the fp_unit issue arbiter.
// Operation bundles, arbiter state and op classification.
package fp_issue_arbiter_pkg;

  typedef enum logic [3:0] {
    FP_FADD,
    FP_FSUB,
    FP_FMUL,
    FP_FMADD,
    FP_FDIV,
    FP_FSQRT,
    FP_FMIN,
    FP_FMAX,
    FP_FCVT,
    FP_FCMP
  } fp_op_type;

  typedef struct packed {
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    fp_op_type   op;
    logic        enable;
  } fp_exe_in_type;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  flags;
    logic        ready;
  } fp_exe_out_type;

  localparam fp_exe_in_type init_fp_operation = '0;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PIPE,
    ARB_ITER
  } fp_arb_state_type;

  function automatic logic is_iter(input fp_op_type op);
    return (op == FP_FDIV) || (op == FP_FSQRT);
  endfunction

endpackage

// File: rtl/fp_owner_fifo.sv
// In-order owner tags for ops in flight inside fp_unit.
// Pointers and occupancy are owned by the arbiter register.
module fp_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int OW    = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          reset,
  input  logic          clock,
  input  logic          push,
  input  logic [PW-1:0] wptr,
  input  logic [PW-1:0] rptr,
  input  logic [PW:0]   count,
  input  logic [OW-1:0] din,
  output logic [OW-1:0] head,
  output logic          empty,
  output logic          full
);

  logic [OW-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= din;
    end
  end

  assign head  = mem[rptr];
  assign empty = (count == '0);
  assign full  = (count == (PW+1)'(DEPTH));

endmodule

// File: rtl/fp_issue_arbiter.sv
// Round-robin issue of NREQ requesters onto one fp_unit,
// with in-order routing of results back to their owners.
module fp_issue_arbiter
  import fp_issue_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int DEPTH = 4
) (
  input  logic           reset,
  input  logic           clock,
  input  logic [NREQ-1:0] req_valid,
  input  fp_exe_in_type  req_op [NREQ],
  output logic [NREQ-1:0] req_ready,
  output fp_exe_in_type  fp_exe_i,
  input  fp_exe_out_type fp_exe_o,
  output logic [NREQ-1:0] resp_valid,
  output logic [31:0]    resp_result,
  output logic [4:0]     resp_flags,
  output logic           err
);

  localparam int OW = $clog2(NREQ);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    fp_arb_state_type state;
    logic [CW-1:0]    count;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [OW-1:0]    last_grant;
    logic             err;
  } fp_arb_reg_type;

  localparam fp_arb_reg_type init_fp_arb_reg = '{
    state:      ARB_IDLE,
    count:      '0,
    wptr:       '0,
    rptr:       '0,
    last_grant: OW'(NREQ-1),
    err:        1'b0
  };

  fp_arb_reg_type r, v;
  fp_exe_in_type  exe_q, exe_d;
  logic [NREQ-1:0] rv_q, rv_d;
  logic [31:0]    res_q, res_d;
  logic [4:0]     flg_q, flg_d;

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   grant;
  logic [OW-1:0]     win;
  logic [OW-1:0]     head;
  int                off;
  int                sum;
  logic              any;
  logic              iter_op;
  logic              elig;
  logic              accept;
  logic              retire;
  logic              empty;
  logic              full;

  fp_owner_fifo #(
    .DEPTH (DEPTH),
    .OW    (OW),
    .PW    (PW)
  ) u_owner (
    .reset (reset),
    .clock (clock),
    .push  (accept),
    .wptr  (r.wptr),
    .rptr  (r.rptr),
    .count (r.count),
    .din   (win),
    .head  (head),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    v      = r;
    exe_d  = exe_q;
    exe_d.enable = 1'b0;
    rv_d   = '0;
    res_d  = res_q;
    flg_d  = flg_q;
    grant  = '0;

    // rot[j] is requester (last_grant+1+j) mod NREQ
    dbl = {req_valid, req_valid};
    rot = NREQ'(dbl >> (int'(r.last_grant) + 1));
    any = |req_valid;
    off = 0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (rot[j]) off = j;
    end
    sum = int'(r.last_grant) + 1 + off;
    if (sum >= NREQ) sum = sum - NREQ;
    win = OW'(sum);

    // no skip-ahead: an ineligible winner stalls everyone
    iter_op = is_iter(req_op[win].op);
    if (iter_op) elig = (r.state == ARB_IDLE) && !exe_q.enable;
    else         elig = (r.state != ARB_ITER) && !full;
    accept = any && elig && reset;
    retire = fp_exe_o.ready && !empty;

    if (accept) begin
      grant[win]   = 1'b1;
      exe_d        = req_op[win];
      exe_d.enable = 1'b1;
      v.last_grant = win;
    end

    if (retire) begin
      rv_d[head] = 1'b1;
      res_d      = fp_exe_o.result;
      flg_d      = fp_exe_o.flags;
    end
    if (fp_exe_o.ready && empty) v.err = 1'b1;

    v.wptr  = r.wptr + PW'(accept);
    v.rptr  = r.rptr + PW'(retire);
    v.count = r.count + CW'(accept) - CW'(retire);

    unique case (r.state)
      ARB_IDLE: if (accept) v.state = iter_op ? ARB_ITER : ARB_PIPE;
      ARB_PIPE: if (retire && !accept && r.count == CW'(1))
                  v.state = ARB_IDLE;
      ARB_ITER: if (retire) v.state = ARB_IDLE;
      default:  v.state = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r     <= init_fp_arb_reg;
      exe_q <= init_fp_operation;
      rv_q  <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      r     <= v;
      exe_q <= exe_d;
      rv_q  <= rv_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end

  assign req_ready   = grant;
  assign fp_exe_i    = exe_q;
  assign resp_valid  = rv_q;
  assign resp_result = res_q;
  assign resp_flags  = flg_q;
  assign err         = r.err;

endmodule

// File: tb/tb_fp_issue_arbiter.sv
// Directed bench for fp_issue_arbiter; the bench plays fp_unit
// and drives ready/result by hand on chosen cycles.
module tb_fp_issue_arbiter;
  import fp_issue_arbiter_pkg::*;

  logic           reset;
  logic           clock;
  logic [2:0]     req_valid;
  fp_exe_in_type  req_op [3];
  logic [2:0]     req_ready;
  fp_exe_in_type  fp_exe_i;
  fp_exe_out_type fp_exe_o;
  logic [2:0]     resp_valid;
  logic [31:0]    resp_result;
  logic [4:0]     resp_flags;
  logic           err;

  int checks   = 0;
  int failures = 0;

  fp_issue_arbiter #(
    .NREQ  (3),
    .DEPTH (4)
  ) dut (
    .reset       (reset),
    .clock       (clock),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_ready   (req_ready),
    .fp_exe_i    (fp_exe_i),
    .fp_exe_o    (fp_exe_o),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic fp_exe_in_type mk(input fp_op_type op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    fp_exe_in_type o;
    o       = '0;
    o.op    = op;
    o.data1 = a;
    o.data2 = b;
    return o;
  endfunction

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic unit(input logic rdy, input logic [31:0] res,
                      input logic [4:0] flg);
    fp_exe_o.ready  = rdy;
    fp_exe_o.result = res;
    fp_exe_o.flags  = flg;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    unit(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) req_op[i] = '0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    unit(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) req_op[i] = '0;
    cyc();
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_exe", 64'(fp_exe_i != '0), 64'd0);
    check("rst_resp", 64'(resp_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    cyc();
    reset = 1'b1;

    // single requester fadd
    req_op[0] = mk(FP_FADD, 32'h3F800000, 32'h40000000);
    req_valid = 3'b001;
    #1 check("single_ready", 64'(req_ready), 64'b001);
    cyc();
    req_valid = '0;
    #1 check("single_en", 64'(fp_exe_i.enable), 64'd1);
    check("single_op", 64'(fp_exe_i.op), 64'(FP_FADD));
    check("single_d2", 64'(fp_exe_i.data2), 64'h40000000);
    cyc();
    unit(1'b1, 32'h40400000, 5'd0);
    #1 check("single_en_drop", 64'(fp_exe_i.enable), 64'd0);
    check("single_hold", 64'(fp_exe_i.data1), 64'h3F800000);
    cyc();
    unit(1'b0, '0, '0);
    #1 check("single_rv", 64'(resp_valid), 64'b001);
    check("single_res", 64'(resp_result), 64'h40400000);
    check("single_flg", 64'(resp_flags), 64'd0);
    cyc();
    #1 check("single_rv_drop", 64'(resp_valid), 64'd0);

    // fairness: three fmul streams, unit latency two cycles
    do_reset();
    for (int i = 0; i < 3; i++)
      req_op[i] = mk(FP_FMUL, 32'h40000000 + i, 32'h3F800000);
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 3'b111 : 3'b000;
      unit(c >= 2 && c <= 7, 32'h100 + c, 5'(c));
      #1;
      check($sformatf("fair_grant%0d", c), 64'(req_ready),
            64'((c < 6) ? (1 << (c % 3)) : 0));
      check($sformatf("fair_rv%0d", c), 64'(resp_valid),
            64'((c >= 3) ? (1 << ((c - 3) % 3)) : 0));
      if (c >= 3)
        check($sformatf("fair_res%0d", c), 64'(resp_result),
              64'(32'h100 + c - 1));
      cyc();
    end
    #1 check("fair_err", 64'(err), 64'd0);

    // full: DEPTH=4 with unit stalled, then pops on cycles 6,7
    do_reset();
    req_op[0] = mk(FP_FADD, 32'h3F800000, 32'h3F800000);
    for (int c = 0; c < 10; c++) begin
      req_valid = 3'b001;
      unit(c == 6 || c == 7, 32'h200 + c, 5'd0);
      #1;
      check($sformatf("full_ready%0d", c), 64'(req_ready),
            64'((c <= 3 || c == 7 || c == 8) ? 1 : 0));
      check($sformatf("full_rv%0d", c), 64'(resp_valid),
            64'((c == 7 || c == 8) ? 1 : 0));
      cyc();
    end

    // iterative: fdiv waits for IDLE and blocks issue while in flight
    do_reset();
    req_op[0] = mk(FP_FADD, 32'h3F800000, 32'h40000000);
    req_op[1] = mk(FP_FDIV, 32'h3F800000, 32'h40400000);
    for (int c = 0; c < 8; c++) begin
      req_valid = (c <= 3) ? 3'b011 : 3'b001;
      if (c == 2)      unit(1'b1, 32'h40400000, 5'd0);
      else if (c == 6) unit(1'b1, 32'h3EAAAAAB, 5'h01);
      else             unit(1'b0, '0, '0);
      #1;
      check($sformatf("iter_ready%0d", c), 64'(req_ready),
            64'((c == 0 || c == 7) ? 3'b001 : (c == 3) ? 3'b010 : 3'b000));
      if (c == 3) check("iter_rv_add", 64'(resp_valid), 64'b001);
      if (c == 4) begin
        check("iter_en", 64'(fp_exe_i.enable), 64'd1);
        check("iter_op", 64'(fp_exe_i.op), 64'(FP_FDIV));
        check("iter_d2", 64'(fp_exe_i.data2), 64'h40400000);
      end
      if (c == 7) begin
        check("iter_rv", 64'(resp_valid), 64'b010);
        check("iter_res", 64'(resp_result), 64'h3EAAAAAB);
        check("iter_flg", 64'(resp_flags), 64'h01);
      end
      cyc();
    end

    // error: ready with nothing in flight
    do_reset();
    unit(1'b1, 32'hBAD0BAD0, 5'h1F);
    cyc();
    unit(1'b0, '0, '0);
    #1 check("err_set", 64'(err), 64'd1);
    check("err_norv", 64'(resp_valid), 64'd0);
    cyc();
    req_op[0] = mk(FP_FADD, 32'h3F800000, 32'h40000000);
    req_valid = 3'b001;
    #1 check("err_sticky", 64'(err), 64'd1);
    cyc();
    unit(1'b1, 32'h12345678, 5'h10);
    cyc();
    unit(1'b0, '0, '0);
    #1 check("mid_rv", 64'(resp_valid), 64'b001);
    check("mid_en", 64'(fp_exe_i.enable), 64'd1);

    // reset mid-stream with a requester still valid
    reset = 1'b0;
    #1 check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_exe", 64'(fp_exe_i != '0), 64'd0);
    check("mid_rst_rv", 64'(resp_valid), 64'd0);
    check("mid_rst_res", 64'(resp_result), 64'd0);
    check("mid_rst_flg", 64'(resp_flags), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    cyc();
    reset = 1'b1;
    #1 check("post_rst_ready", 64'(req_ready), 64'b001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
